// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Host-facing byte-stream loader that sits directly upstream of the accelerator
// core. It parses a framed byte stream into writes to the core's instruction
// memory (32-bit words) and data memory (bytes). It can also launch the core.
//
// Frame formats, in the order the bytes arrive:
//   0x01 LOAD_INSTR : addr, count, then count*4 payload bytes. Each word is
//                     big-endian: its first byte lands in wdata[31:24].
//   0x02 LOAD_DATA  : addr, count, then count payload bytes.
//   0x03 START      : no further bytes. Pulses start, then blocks input until
//                     the core reports halted.
// Any other command byte sets the sticky err flag. The byte is consumed and
// parsing carries on as normal.
//
// Ports
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   in_data      in   stream byte
//   in_valid     in   in_data valid
//   in_ready     out  loader accepts a byte this cycle (in_valid && in_ready)
//   instr_we     out  one-cycle instruction-memory write strobe
//   instr_addr   out  instruction write address
//   instr_wdata  out  instruction word
//   mem_we       out  one-cycle data-memory write strobe
//   mem_addr     out  data write address
//   mem_wdata    out  data byte
//   start        out  one-cycle run pulse to the core
//   core_halted  in   level, high once the core has executed HALT
//   busy         out  high whenever the parser is not idle
//   err          out  sticky unknown-command flag, cleared only by reset
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int INSTR_DEPTH  = 16,
    parameter int INSTR_ADDR_W = 4,
    parameter int DATA_DEPTH   = 32,
    parameter int DATA_ADDR_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    instr_we,
    output logic [INSTR_ADDR_W-1:0] instr_addr,
    output logic [31:0]             instr_wdata,
    output logic                    mem_we,
    output logic [DATA_ADDR_W-1:0]  mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    start,
    input  logic                    core_halted,
    output logic                    busy,
    output logic                    err
);

    localparam logic [7:0] CMD_LOAD_INSTR = 8'h01;
    localparam logic [7:0] CMD_LOAD_DATA  = 8'h02;
    localparam logic [7:0] CMD_START      = 8'h03;

    localparam logic [INSTR_ADDR_W-1:0] INSTR_LAST = INSTR_ADDR_W'(INSTR_DEPTH - 1);
    localparam logic [DATA_ADDR_W-1:0]  DATA_LAST  = DATA_ADDR_W'(DATA_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_ADDR,
        S_HDR_CNT,
        S_PAYLOAD,
        S_START_PULSE,
        S_WAIT_DONE
    } state_t;

    // Parser state
    state_t                  state_q;
    state_t                  state_d;
    logic                    is_instr_q;     // frame kind: 1 = LOAD_INSTR, 0 = LOAD_DATA
    logic [INSTR_ADDR_W-1:0] instr_ptr_q;    // address of the next instruction word
    logic [DATA_ADDR_W-1:0]  data_ptr_q;     // address of the next data byte
    logic [7:0]              remaining_q;    // units (words or bytes) still to write
    logic [1:0]              byte_cnt_q;     // byte position within the current word
    logic [23:0]             asm_q;          // first three bytes of the current word

    // Registered outputs
    logic                    in_ready_q;
    logic                    instr_we_q;
    logic [INSTR_ADDR_W-1:0] instr_addr_q;
    logic [31:0]             instr_wdata_q;
    logic                    mem_we_q;
    logic [DATA_ADDR_W-1:0]  mem_addr_q;
    logic [7:0]              mem_wdata_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    err_q;

    // Combinational helpers
    logic                    accept;
    logic                    unit_done;
    logic [INSTR_ADDR_W-1:0] instr_ptr_d;
    logic [DATA_ADDR_W-1:0]  data_ptr_d;
    logic [31:0]             word_d;

    assign accept    = in_valid && in_ready_q;
    // A data byte is a complete unit on its own. An instruction word is
    // complete only on its fourth byte.
    assign unit_done = is_instr_q ? (byte_cnt_q == 2'd3) : 1'b1;
    assign word_d    = {asm_q, in_data};

    // Address pointers wrap to 0 at the end of each memory. With count larger
    // than the depth, later units silently overwrite earlier ones.
    assign instr_ptr_d = (instr_ptr_q == INSTR_LAST) ? '0 : instr_ptr_q + 1'b1;
    assign data_ptr_d  = (data_ptr_q  == DATA_LAST)  ? '0 : data_ptr_q  + 1'b1;

    // Next-state selection. in_ready and busy are registered from state_d, so
    // they line up exactly with the state they describe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_data == CMD_LOAD_INSTR || in_data == CMD_LOAD_DATA) begin
                        state_d = S_HDR_ADDR;
                    end else if (in_data == CMD_START) begin
                        state_d = S_START_PULSE;
                    end
                end
            end
            S_HDR_ADDR: begin
                if (accept) begin
                    state_d = S_HDR_CNT;
                end
            end
            S_HDR_CNT: begin
                if (accept) begin
                    state_d = (in_data == 8'h00) ? S_IDLE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept && unit_done && remaining_q == 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_START_PULSE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // core_halted is first sampled one full cycle after the
                // pulse. This gives the core time to clear a stale halt.
                if (core_halted) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            is_instr_q    <= 1'b0;
            instr_ptr_q   <= '0;
            data_ptr_q    <= '0;
            remaining_q   <= 8'd0;
            byte_cnt_q    <= 2'd0;
            asm_q         <= 24'd0;
            in_ready_q    <= 1'b1;
            instr_we_q    <= 1'b0;
            instr_addr_q  <= '0;
            instr_wdata_q <= 32'd0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'd0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_START_PULSE) && (state_d != S_WAIT_DONE);
            busy_q     <= (state_d != S_IDLE);

            // Strobes are single-cycle unless re-asserted below.
            instr_we_q <= 1'b0;
            mem_we_q   <= 1'b0;
            start_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (in_data)
                            CMD_LOAD_INSTR: is_instr_q <= 1'b1;
                            CMD_LOAD_DATA:  is_instr_q <= 1'b0;
                            CMD_START:      start_q    <= 1'b1;
                            default:        err_q      <= 1'b1;
                        endcase
                    end
                end
                S_HDR_ADDR: begin
                    if (accept) begin
                        // Only the low address bits matter. Both pointers are
                        // loaded so the payload step need not re-check the kind.
                        instr_ptr_q <= in_data[INSTR_ADDR_W-1:0];
                        data_ptr_q  <= in_data[DATA_ADDR_W-1:0];
                    end
                end
                S_HDR_CNT: begin
                    if (accept) begin
                        remaining_q <= in_data;
                        byte_cnt_q  <= 2'd0;
                        asm_q       <= 24'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        if (is_instr_q) begin
                            if (unit_done) begin
                                instr_we_q    <= 1'b1;
                                instr_addr_q  <= instr_ptr_q;
                                instr_wdata_q <= word_d;
                                instr_ptr_q   <= instr_ptr_d;
                                remaining_q   <= remaining_q - 8'd1;
                                byte_cnt_q    <= 2'd0;
                                asm_q         <= 24'd0;
                            end else begin
                                // Big-endian: earlier bytes shift toward the MSB.
                                asm_q      <= {asm_q[15:0], in_data};
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                            end
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= data_ptr_q;
                            mem_wdata_q <= in_data;
                            data_ptr_q  <= data_ptr_d;
                            remaining_q <= remaining_q - 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign instr_we    = instr_we_q;
    assign instr_addr  = instr_addr_q;
    assign instr_wdata = instr_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
